serial_addsub: RTL and testbench

Parametrised multi-cycle adder/subtractor that processes `BITS_PER_CYCLE` bit slices of two `WIDTH`-bit unsigned operands per clock, LSB-first. It produces sum or difference, carry/borrow, and greater/equal/less flags. It is the sequential, width-generic successor to the single-bit adder/subtractor and 2-bit comparator cells. It sits in datapaths where area matters more than throughput and talks to its controller through a start/busy/done handshake.

---
 rtl/serial_addsub_if.sv | 36 +++
 rtl/serial_addsub.sv | 172 +++++++++++++++++
 tb/tb_serial_addsub.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
// Handshake and result bundle between a datapath controller and serial_addsub.
// The gray signal exists only when SERIAL_ADDSUB_GRAY_EN is defined.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             a_greater;
    logic             a_equal;
    logic             a_less;
`ifdef SERIAL_ADDSUB_GRAY_EN
    logic [WIDTH-1:0] gray;
`endif

    modport master (
        output start, mode, a, b,
        input  busy, done, result, carry, a_greater, a_equal, a_less
`ifdef SERIAL_ADDSUB_GRAY_EN
        , input gray
`endif
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, result, carry, a_greater, a_equal, a_less
`ifdef SERIAL_ADDSUB_GRAY_EN
        , output gray
`endif
    );
endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle LSB-first adder/subtractor with unsigned compare, BITS_PER_CYCLE bits per clock.
// Optional registered Gray-coded result output enabled by SERIAL_ADDSUB_GRAY_EN.

// One bit of the slice: add/sub ripple plus compare chain (higher bit overrides lower).
module serial_addsub_cell (
    input  logic a,
    input  logic b,
    input  logic sub,
    input  logic ci,
    input  logic gi,
    input  logic li,
    output logic s,
    output logic co,
    output logic go,
    output logic lo
);
    assign s  = a ^ b ^ ci;
    assign co = sub ? ((~a & b) | ((~a | b) & ci))
                    : ((a & b) | (b & ci) | (a & ci));
    assign go = (a & ~b) | (gi & ~(a ^ b));
    assign lo = (~a & b) | (li & ~(a ^ b));
endmodule

module serial_addsub #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic            clk,
    input logic            rst_n,
    serial_addsub_if.slave bus
);
    localparam int B  = (BITS_PER_CYCLE < 1) ? 1 : BITS_PER_CYCLE;
    localparam int N  = WIDTH / B;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % B) != 0) begin : g_bad_params
            $fatal(1, "serial_addsub: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE >= 1");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;
    logic   accept, last;

    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic             mode_q, c_q, gt_q, lt_q;
    logic [CW-1:0]    cnt;

    logic             done_q, carry_q, gt_o, eq_o, lt_o;
    logic [WIDTH-1:0] result_q;

    // Slice chains: index 0 is the running state entering this cycle
    logic [B:0]           c_ch, g_ch, l_ch;
    logic [B-1:0]         s_sl;
    logic [WIDTH+B-1:0]   res_cat;
    logic [WIDTH-1:0]     res_nxt;

    assign c_ch[0] = c_q;
    assign g_ch[0] = gt_q;
    assign l_ch[0] = lt_q;

    generate
        for (genvar i = 0; i < B; i++) begin : g_bit
            serial_addsub_cell u_cell (
                .a  (a_sh[i]),
                .b  (b_sh[i]),
                .sub(mode_q),
                .ci (c_ch[i]),
                .gi (g_ch[i]),
                .li (l_ch[i]),
                .s  (s_sl[i]),
                .co (c_ch[i+1]),
                .go (g_ch[i+1]),
                .lo (l_ch[i+1])
            );
        end
    endgenerate

    // New slice enters from the MSB side; after N slices the LSB slice sits at the bottom
    assign res_cat = {s_sl, res_sh};
    assign res_nxt = res_cat[WIDTH+B-1:B];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(N - 1)) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SERIAL_ADDSUB_GRAY_EN
    logic [WIDTH-1:0] gray_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    gray_q <= '0;
        else if (last) gray_q <= res_nxt ^ (res_nxt >> 1);
    end
    assign bus.gray = gray_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            mode_q   <= 1'b0;
            c_q      <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            cnt      <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            gt_o     <= 1'b0;
            eq_o     <= 1'b0;
            lt_o     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_sh   <= bus.a;
                b_sh   <= bus.b;
                mode_q <= bus.mode;
                cnt    <= '0;
                c_q    <= 1'b0;
                gt_q   <= 1'b0;
                lt_q   <= 1'b0;
            end else if (state == RUN) begin
                a_sh   <= a_sh >> B;
                b_sh   <= b_sh >> B;
                res_sh <= res_nxt;
                c_q    <= c_ch[B];
                gt_q   <= g_ch[B];
                lt_q   <= l_ch[B];
                cnt    <= cnt + CW'(1);
                if (last) begin
                    result_q <= res_nxt;
                    carry_q  <= c_ch[B];
                    gt_o     <= g_ch[B];
                    lt_o     <= l_ch[B];
                    eq_o     <= ~(g_ch[B] | l_ch[B]);
                    done_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.a_greater = gt_o;
    assign bus.a_equal   = eq_o;
    assign bus.a_less    = lt_o;
endmodule

// File: tb/tb_serial_addsub.sv
// Randomised self-checking bench for serial_addsub: one instance at 1 bit/cycle, one at 4 bits/cycle,
// compared against plain-arithmetic expectations (a+b / a-b and relational compare).
module tb_serial_addsub;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_addsub_if #(.WIDTH(8)) if1 ();
    serial_addsub_if #(.WIDTH(8)) if4 ();

    serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Selected instance: 0 -> 1 bit/cycle, 1 -> 4 bits/cycle
    logic       cur = 1'b0;
    wire        o_busy = cur ? if4.busy      : if1.busy;
    wire        o_done = cur ? if4.done      : if1.done;
    wire [7:0]  o_res  = cur ? if4.result    : if1.result;
    wire        o_cy   = cur ? if4.carry     : if1.carry;
    wire        o_gt   = cur ? if4.a_greater : if1.a_greater;
    wire        o_eq   = cur ? if4.a_equal   : if1.a_equal;
    wire        o_lt   = cur ? if4.a_less    : if1.a_less;
`ifdef SERIAL_ADDSUB_GRAY_EN
    wire [7:0]  o_gray = cur ? if4.gray      : if1.gray;
`endif

    task automatic drive(input logic s, input logic m, input logic [7:0] x, input logic [7:0] y);
        if (cur) begin
            if4.start = s; if4.mode = m; if4.a = x; if4.b = y;
        end else begin
            if1.start = s; if1.mode = m; if1.a = x; if1.b = y;
        end
    endtask

    // Called just after a negedge. Drives a request, waits (bounded) for done, checks everything.
    // ign_at: cycle at which a spurious start with other operands is pulsed; keep: leave start high.
    task automatic do_op(input logic sel, input logic m, input logic [7:0] x, input logic [7:0] y,
                         input int ign_at, input logic keep);
        int          n_exp, lat, bsy;
        logic [8:0]  wide;
        logic [7:0]  r;
        cur   = sel;
        n_exp = sel ? 2 : 8;
        wide  = m ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
        r     = wide[7:0];
        drive(1'b1, m, x, y);
        lat = -1;
        bsy = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == ign_at)  drive(1'b1, ~m, $urandom_range(0, 255), $urandom_range(0, 255));
            else if (!keep)   drive(1'b0, m, x, y);
            if (o_busy) bsy++;
            if (o_done) begin
                lat = k - 1;
                break;
            end
        end
        chk("latency",   lat, n_exp);
        chk("busy_cyc",  bsy, n_exp);
        chk("busy_done", o_busy, 1'b0);
        chk("result",    o_res, r);
        chk("carry",     o_cy, wide[8]);
        chk("a_greater", o_gt, x > y);
        chk("a_equal",   o_eq, x == y);
        chk("a_less",    o_lt, x < y);
        chk("onehot",    32'(o_gt) + 32'(o_eq) + 32'(o_lt), 1);
`ifdef SERIAL_ADDSUB_GRAY_EN
        chk("gray",      o_gray, r ^ (r >> 1));
`endif
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy1"}, {if1.busy, if1.done, if1.carry, if1.a_greater, if1.a_equal, if1.a_less}, 0);
        chk({tag, "_res1"},  if1.result, 0);
        chk({tag, "_busy4"}, {if4.busy, if4.done, if4.carry, if4.a_greater, if4.a_equal, if4.a_less}, 0);
        chk({tag, "_res4"},  if4.result, 0);
`ifdef SERIAL_ADDSUB_GRAY_EN
        chk({tag, "_gray"},  {if1.gray, if4.gray}, 0);
`endif
    endtask

    initial begin
        int saw_done;
        rst_n = 1'b0;
        cur = 1'b0; drive(1'b0, 1'b0, 8'h00, 8'h00);
        cur = 1'b1; drive(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        do_op(1'b0, 1'b0, 8'h5A, 8'h3C, 0, 1'b0);
        do_op(1'b0, 1'b1, 8'h10, 8'h20, 0, 1'b0);
        do_op(1'b0, 1'b0, 8'hFF, 8'h01, 0, 1'b0);
        do_op(1'b1, 1'b1, 8'hA5, 8'hA5, 0, 1'b1);
        // start still high through done: next op accepted with no gap, latency 2 again
        do_op(1'b1, 1'b0, 8'h33, 8'hC4, 0, 1'b0);

        // Spurious start mid-operation is ignored; results then hold
        do_op(1'b0, 1'b0, 8'h5A, 8'h3C, 3, 1'b0);
        @(negedge clk);
        chk("hold_done", o_done, 1'b0);
        chk("hold_res",  o_res, 8'h96);
        chk("hold_gt",   o_gt, 1'b1);

        // Asynchronous reset mid-operation
        cur = 1'b0;
        drive(1'b1, 1'b0, 8'h12, 8'h34);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h12, 8'h34);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_state("midrst");
        saw_done = 0;
        repeat (2) begin
            @(negedge clk);
            if (if1.done) saw_done++;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (if1.done || if1.busy) saw_done++;
        end
        chk("no_done_after_rst", saw_done, 0);
        do_op(1'b0, 1'b1, 8'h80, 8'h7F, 0, 1'b0);

        // Random sweep across both modes and both instances
        for (int i = 0; i < 300; i++)
            do_op(i % 3 == 0, $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 255), 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
